// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: AHB-Lite transfer/response encodings and interconnect FSM states
package ahb_lite_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [1:0] {ST_PASS, ST_ERR1, ST_ERR2} state_t;
endpackage

// File: rtl/ahb_lite_addr_decoder.sv
// ahb_lite_addr_decoder: base/mask address decode, lowest index wins, one-hot select
module ahb_lite_addr_decoder #(
    parameter int NSLV = 8,
    parameter int IW = 3,
    parameter logic [NSLV*32-1:0] SLV_BASE = {NSLV{32'h0}},
    parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'h0}}
) (
    input  logic [31:0]     addr,
    output logic [NSLV-1:0] sel,
    output logic            hit,
    output logic [IW-1:0]   idx
);
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NSLV - 1; i >= 0; i--)
            if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        sel = hit ? NSLV'(1) << idx : '0;
    end
endmodule

// File: rtl/ahb_lite_param_interconnect.sv
// ahb_lite_param_interconnect: single-master AHB-Lite decoder, data-phase mux,
// default slave with ERROR response, stall watchdog and sticky fault status
module ahb_lite_param_interconnect
    import ahb_lite_pkg::*;
#(
    parameter int NSLV = 8,
    parameter int DW = 32,
    parameter logic [NSLV*32-1:0] SLV_BASE = {NSLV{32'h0}},
    parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'h0}},
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    output logic             HREADY,
    output logic             HRESP,
    output logic [DW-1:0]    HRDATA,
    output logic [NSLV-1:0]  HSEL_A,
    input  logic [NSLV-1:0]  HREADYOUT_A,
    input  logic [NSLV-1:0]  HRESP_A,
    input  logic [NSLV*DW-1:0] HRDATA_A,
    input  logic             FAULT_CLR,
    output logic             FAULT_VALID,
    output logic             FAULT_TO,
    output logic [31:0]      FAULT_ADDR,
    output logic [7:0]       FAULT_CNT
);
    localparam int IW = NSLV > 1 ? $clog2(NSLV) : 1;
    localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC);

    state_t        state, state_nxt;
    logic          hit, dsel_hit, active, stall, timeout, new_err, enter;
    logic [IW-1:0] idx, dsel;
    logic [31:0]   daddr;
    logic [CW-1:0] wd_cnt;
    logic [7:0]    cnt_base;

    ahb_lite_addr_decoder #(
        .NSLV(NSLV), .IW(IW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
    ) u_dec (
        .addr(HADDR), .sel(HSEL_A), .hit(hit), .idx(idx)
    );

    // dsel_hit=0 is the built-in default slave
    assign HREADY  = state == ST_PASS ? (dsel_hit ? HREADYOUT_A[dsel] : 1'b1) : state == ST_ERR2;
    assign HRESP   = state != ST_PASS ? HRESP_ERROR : dsel_hit ? HRESP_A[dsel] : HRESP_OKAY;
    assign HRDATA  = state == ST_PASS && dsel_hit ? HRDATA_A[DW*dsel +: DW] : '0;
    assign active  = HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ;
    assign new_err = HREADY && !hit && active;
    assign stall   = state == ST_PASS && dsel_hit && !HREADYOUT_A[dsel];
    assign timeout = TIMEOUT_CYC != 0 && stall && wd_cnt == TO_LIM - 1'b1;
    assign enter   = state_nxt == ST_ERR1;
    // a clear coinciding with a new fault restarts the count at one
    assign cnt_base = FAULT_CLR ? 8'h00 : FAULT_CNT;

    always_comb begin
        state_nxt = ST_PASS;
        state_nxt = state == ST_ERR1 ? ST_ERR2 : (new_err || timeout) ? ST_ERR1 : ST_PASS;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state       <= ST_PASS;
            dsel_hit    <= 1'b0;
            dsel        <= '0;
            daddr       <= '0;
            wd_cnt      <= '0;
            FAULT_VALID <= 1'b0;
            FAULT_TO    <= 1'b0;
            FAULT_ADDR  <= '0;
            FAULT_CNT   <= '0;
        end else begin
            state  <= state_nxt;
            wd_cnt <= TIMEOUT_CYC != 0 && stall ? wd_cnt + 1'b1 : '0;
            if (HREADY) begin
                dsel_hit <= hit;
                dsel     <= idx;
                daddr    <= HADDR;
            end
            if (enter) begin
                FAULT_VALID <= 1'b1;
                FAULT_TO    <= timeout;
                FAULT_ADDR  <= HREADY ? HADDR : daddr;
                FAULT_CNT   <= cnt_base == 8'hFF ? cnt_base : cnt_base + 1'b1;
            end else if (FAULT_CLR) begin
                FAULT_VALID <= 1'b0;
                FAULT_TO    <= 1'b0;
                FAULT_ADDR  <= '0;
                FAULT_CNT   <= '0;
            end
        end
    end
endmodule
